// File: rtl/hdd_pkg.sv
// Shared definitions for the ProDOS HDD interface and its SD block-transfer controller.
package hdd_pkg;

  localparam int unsigned HDD_SECTOR_BYTES = 512;
  localparam int unsigned HDD_BYTE_ADDR_W  = 9;
  localparam int unsigned HDD_BYTE_CNT_W   = 10;
  localparam int unsigned HDD_DATA_W       = 8;
  localparam int unsigned HDD_SECTOR_W     = 16;
  localparam int unsigned HDD_LBA_W        = 32;
  localparam int unsigned HDD_TMO_W        = 24;

  localparam logic HDD_OP_READ  = 1'b0;
  localparam logic HDD_OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DONE
  } hdd_xfer_state_t;

  // Command latched when a request is accepted.
  typedef struct packed {
    logic                    op;
    logic [HDD_SECTOR_W-1:0] sector;
  } hdd_cmd_t;

endpackage

// File: rtl/hdd_sd_ctrl.sv
// SD block-transfer controller: turns HDD read/write pulses into a host block
// request and streams the 512-byte block between the host and the sector buffer.
module hdd_sd_ctrl
  import hdd_pkg::*;
#(
  parameter logic [HDD_TMO_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic                       CLK_14M,
  input  logic                       RESET,
  input  logic                       hdd_read,
  input  logic                       hdd_write,
  input  logic [HDD_SECTOR_W-1:0]    sector,
  input  logic                       hdd_mounted,
  output logic                       busy,
  output logic                       err,
  output logic [HDD_LBA_W-1:0]       sd_lba,
  output logic                       sd_rd,
  output logic                       sd_wr,
  input  logic                       sd_ack,
  input  logic [HDD_BYTE_ADDR_W-1:0] sd_buff_addr,
  input  logic [HDD_DATA_W-1:0]      sd_buff_dout,
  input  logic                       sd_buff_wr,
  output logic [HDD_DATA_W-1:0]      sd_buff_din,
  output logic [HDD_BYTE_ADDR_W-1:0] ram_addr,
  output logic [HDD_DATA_W-1:0]      ram_di,
  output logic                       ram_we,
  input  logic [HDD_DATA_W-1:0]      ram_do
);

  localparam logic [HDD_TMO_W-1:0]      TMO_LAST   = TIMEOUT_CYCLES - HDD_TMO_W'(1);
  localparam logic [HDD_BYTE_CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [HDD_BYTE_CNT_W-1:0] CNT_SECTOR = HDD_BYTE_CNT_W'(HDD_SECTOR_BYTES);

  hdd_xfer_state_t             state_q, state_d;
  hdd_cmd_t                    cmd_q, cmd_d;
  logic                        rd_prev_q, wr_prev_q;
  logic [HDD_TMO_W-1:0]        tmo_q, tmo_d;
  logic [HDD_BYTE_CNT_W-1:0]   cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic                        busy_q, busy_d;
  logic                        sd_rd_q, sd_rd_d;
  logic                        sd_wr_q, sd_wr_d;
  logic [HDD_BYTE_ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [HDD_DATA_W-1:0]       ram_di_q, ram_di_d;
  logic [HDD_DATA_W-1:0]       din_q, din_d;

  logic rd_edge, wr_edge, accept, in_xfer, xfer_read, xfer_write;

  // Request edges; only honoured in IDLE with an image mounted.
  assign rd_edge    = hdd_read & ~rd_prev_q;
  assign wr_edge    = hdd_write & ~wr_prev_q;
  assign accept     = (state_q == IDLE) & hdd_mounted & (rd_edge | wr_edge);
  assign in_xfer    = (state_q == XFER);
  assign xfer_read  = in_xfer & (cmd_q.op == HDD_OP_READ);
  assign xfer_write = in_xfer & (cmd_q.op == HDD_OP_WRITE);

  // State register.
  always_ff @(posedge CLK_14M) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; an ack arriving on the last timeout clock still wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ: begin
        if (sd_ack)                 state_d = XFER;
        else if (tmo_q == TMO_LAST) state_d = DONE;
      end
      XFER:    if (!sd_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cmd_d      = cmd_q;
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ram_addr_d = ram_addr_q;
    ram_di_d   = ram_di_q;
    din_d      = din_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d.op     = rd_edge ? HDD_OP_READ : HDD_OP_WRITE;
          cmd_d.sector = sector;
          tmo_d        = '0;
          cnt_d        = '0;
          err_d        = 1'b0;
        end
      end
      REQ: begin
        tmo_d = tmo_q + HDD_TMO_W'(1);
        if (!sd_ack && (tmo_q == TMO_LAST)) err_d = 1'b1;
      end
      XFER: begin
        ram_addr_d = sd_buff_addr;
        if (cmd_q.op == HDD_OP_READ) begin
          ram_di_d = sd_buff_dout;
          if (sd_buff_wr && sd_ack && (cnt_q != CNT_MAX)) cnt_d = cnt_q + HDD_BYTE_CNT_W'(1);
          if (!sd_ack && (cnt_q != CNT_SECTOR)) err_d = 1'b1;
        end else begin
          din_d = ram_do;
        end
      end
      default: ;
    endcase
    busy_d  = (state_d != IDLE);
    sd_rd_d = (state_d == REQ) && (cmd_d.op == HDD_OP_READ);
    sd_wr_d = (state_d == REQ) && (cmd_d.op == HDD_OP_WRITE);
  end

  // Registered outputs, counters and edge-detect flops.
  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      rd_prev_q  <= 1'b0;
      wr_prev_q  <= 1'b0;
      cmd_q      <= '0;
      tmo_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      sd_rd_q    <= 1'b0;
      sd_wr_q    <= 1'b0;
      ram_addr_q <= '0;
      ram_di_q   <= '0;
      din_q      <= '0;
    end else begin
      rd_prev_q  <= hdd_read;
      wr_prev_q  <= hdd_write;
      cmd_q      <= cmd_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      sd_rd_q    <= sd_rd_d;
      sd_wr_q    <= sd_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_di_q   <= ram_di_d;
      din_q      <= din_d;
    end
  end

  // Buffer port follows the host directly during a transfer, holds otherwise.
  assign ram_addr    = in_xfer ? sd_buff_addr : ram_addr_q;
  assign ram_di      = xfer_read ? sd_buff_dout : ram_di_q;
  assign ram_we      = xfer_read & sd_buff_wr & sd_ack;
  assign sd_buff_din = xfer_write ? ram_do : din_q;

  assign busy   = busy_q;
  assign err    = err_q;
  assign sd_rd  = sd_rd_q;
  assign sd_wr  = sd_wr_q;
  assign sd_lba = HDD_LBA_W'(cmd_q.sector);

endmodule
